regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Owns the single write port of the 32x32 register file (`rw5`/`regWrite5`/`Busw`) and shares it between the in-order pipeline writeback stage and the long-latency multiply/divide unit. Buffers out-of-band results in a small FIFO and keeps a 32-bit busy scoreboard of destinations with results still outstanding. Exports stall signals to the hazard logic in decode. Sits between WB, the mul/div unit and the register file.

## Interface
- `LL_DEPTH`, 2: result FIFO depth; legal values are 2 and 4.
- `STARVE_LIMIT`, 4: consecutive lost arbitration cycles before WB is forced to stall (1..15).
- `CLK` in 1: clock; all state updates on posedge.
- `Reset_L` in 1: reset, synchronous, active-low.
- `wb_valid` in 1: pipeline writeback request.
- `wb_rw` in 5: WB destination.
- `wb_data` in 32: WB data.
- `ll_issue` in 1: mul/div op issued this cycle.
- `ll_issue_rw` in 5: destination of the issued op.
- `ll_valid` in 1: mul/div result valid.
- `ll_rw` in 5: result destination.
- `ll_data` in 32: result data.
- `ll_ready` out 1: FIFO can accept a result.
- `rs_q` in 5: decode source register query.
- `rt_q` in 5: decode source register query.
- `raw_stall` out 1: `busy[rs_q] | busy[rt_q]`.
- `issue_ok` out 1: `!busy[ll_issue_rw]` and FIFO not full.
- `wb_stall` out 1: WB denied this cycle; pipeline holds WB inputs.
- `rw5` out 5: register file write address.
- `regWrite5` out 1: register file write enable.
- `Busw` out 32: register file write data.

## Operation
- **Scoreboard:**
  - `busy[31:0]`; bit 0 is never set.
  - `ll_issue` with `issue_ok=1` and `ll_issue_rw!=0` sets `busy[ll_issue_rw]`.
  - `ll_issue` with `issue_ok=0` is a protocol error: it is ignored and the scoreboard is unchanged.
  - A busy bit clears on the edge where its FIFO head commits to the register file. Decode therefore reads the new value the cycle after the clear.
  - Set and clear of the same register cannot coincide, because issue is blocked while the register is busy.
- **FIFO:**
  - `ll_valid & ll_ready` pushes `{ll_rw, ll_data}`.
  - `ll_ready = !full`, registered-state only. There is no pass-through on a pop in the same cycle.
  - A result with `ll_rw==0` is pushed and popped normally; it performs no write (`regWrite5=0`).
- **Arbitration (combinational from registered state and inputs):**
  - WB "wants" the port when `wb_valid && wb_rw!=0`.
  - Force condition: FIFO non-empty and `starve_cnt==STARVE_LIMIT`. In that case `wb_stall=1` and the FIFO head commits.
  - Otherwise, if WB wants the port, WB writes, `wb_stall=0`, and the head waits.
  - Otherwise, if the FIFO is non-empty, the head commits.
  - Otherwise `regWrite5=0` and `rw5`/`Busw` are 0.
- **Starvation counter:**
  - `starve_cnt` increments when the FIFO is non-empty and the head did not commit, saturating at `STARVE_LIMIT`.
  - It clears on every head commit and whenever the FIFO is empty.
- **Reset (`Reset_L=0` at posedge):**
  - FIFO pointers, `busy` and `starve_cnt` are cleared.
  - While `Reset_L=0`, outputs are forced: `regWrite5=0`, `rw5=0`, `Busw=0`, `wb_stall=0`, `raw_stall=0`, `ll_ready=0`, `issue_ok=0`.
  - Reset mid-operation discards buffered results; no write is issued.

## Timing
- Minimum result latency is 1 cycle: a result pushed at edge N can be written to the register file at edge N+1.
- WB path latency is 0: same-cycle pass-through to the write port.
- Worst-case head wait with `RFSCHED_STARVE_GUARD_EN` defined is `STARVE_LIMIT` cycles.
- `raw_stall` and `issue_ok` are combinational from `busy`, the FIFO state and the query inputs.
- Full FIFO: `ll_ready=0`. The mul/div unit holds `ll_valid`/`ll_rw`/`ll_data` stable until accepted.

## Configuration
- `RFSCHED_STARVE_GUARD_EN` defined: the starvation counter and forced `wb_stall` are built as described above.
- `RFSCHED_STARVE_GUARD_EN` undefined:
  - WB has strict priority; `wb_stall` is tied to 0 and the counter is not built.
  - The head commits only in cycles where WB does not want the port.
  - Forward progress relies on pipeline bubbles.

## Test plan
- **Reset:** hold `Reset_L=0` for 2 cycles with all inputs active -> `regWrite5=0`, `ll_ready=0`, and `busy` reads 0 for all 32 queries after release.
- **Scoreboard clear:** issue r5; push r5=0x1234_5678 with `wb_valid=0`.
  - `raw_stall=1` for `rs_q=5` until commit.
  - Commit cycle shows `rw5=5`, `regWrite5=1`, `Busw=0x12345678`.
  - `raw_stall=0` on the following cycle.
- **Starvation:** `STARVE_LIMIT=4`, guard defined; FIFO holds r7 and `wb_valid=1` continuously.
  - WB writes for 4 cycles.
  - Cycle 5: `wb_stall=1` and r7 commits.
  - Cycle 6: WB resumes.
- **Full FIFO and hold:** `LL_DEPTH=2`; push r1 and r2 under continuous WB -> `ll_ready=0` and `issue_ok=0`. A third result held on `ll_valid` is accepted the cycle after the first commit.
- **Register 0:** `ll_issue_rw=0` plus result to r0, and `wb_rw=0` with `wb_valid=1` -> no bit of `busy` set, `regWrite5` never 1, FIFO drains in 1 cycle.
- **Illegal issue:** issue r9 twice back-to-back -> second issue sees `issue_ok=0`, and only one FIFO result is needed to clear `busy[9]`.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - register file write-port arbiter between WB and the mul/div result FIFO
//
// Shares the single register file write port between the in-order writeback
// stage (zero-latency pass-through) and buffered long-latency mul/div results.
// A 32-bit busy scoreboard tracks destinations whose results are outstanding.
//
// Optional feature macro: RFSCHED_STARVE_GUARD_EN
//   defined   - starvation counter forces a FIFO head commit (and wb_stall)
//               after STARVE_LIMIT consecutive lost arbitration cycles.
//   undefined - WB has strict priority, wb_stall is tied to 0.
//
// Parameters:
//   LL_DEPTH     result FIFO depth (2 or 4)
//   STARVE_LIMIT lost cycles before WB is forced to stall (1..15)
//
// Ports:
//   CLK, Reset_L                  clock, synchronous active-low reset
//   wb_valid, wb_rw, wb_data      writeback request
//   ll_issue, ll_issue_rw         mul/div issue notification
//   ll_valid, ll_rw, ll_data      mul/div result, ll_ready accepts it
//   rs_q, rt_q, raw_stall         decode source hazard query
//   issue_ok                      mul/div issue permitted
//   wb_stall                      WB denied this cycle
//   rw5, regWrite5, Busw          register file write port

module regfile_write_scheduler #(
    parameter int LL_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] wb_data,
    input  logic        ll_issue,
    input  logic [4:0]  ll_issue_rw,
    input  logic        ll_valid,
    input  logic [4:0]  ll_rw,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    input  logic [4:0]  rs_q,
    input  logic [4:0]  rt_q,
    output logic        raw_stall,
    output logic        issue_ok,
    output logic        wb_stall,
    output logic [4:0]  rw5,
    output logic        regWrite5,
    output logic [31:0] Busw
);

    localparam int AW = (LL_DEPTH > 2) ? 2 : 1;
    localparam int CW = AW + 1;

    logic [4:0]    fifo_rw   [LL_DEPTH];
    logic [31:0]   fifo_data [LL_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   busy;

    logic          full;
    logic          non_empty;
    logic [4:0]    head_rw;
    logic [31:0]   head_data;
    logic          wb_wants;
    logic          force_head;
    logic          head_commit;
    logic          wb_win;
    logic          push;
    logic [31:0]   set_vec;
    logic [31:0]   clr_vec;

    assign full      = (count == CW'(LL_DEPTH));
    assign non_empty = (count != '0);
    assign head_rw   = fifo_rw[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign wb_wants  = wb_valid && (wb_rw != 5'd0);

`ifdef RFSCHED_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign force_head = non_empty && (starve_cnt == 4'(STARVE_LIMIT));

    // Counts consecutive cycles the head lost to WB; any commit or an empty
    // FIFO restarts the count.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            starve_cnt <= 4'd0;
        end else if (!non_empty || head_commit) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = (STARVE_LIMIT > 0);
    assign force_head          = 1'b0;
`endif

    // Arbitration is gated by reset so no write escapes while Reset_L is low.
    assign head_commit = Reset_L && non_empty && (force_head || !wb_wants);
    assign wb_win      = Reset_L && !force_head && wb_wants;

    assign wb_stall  = Reset_L && force_head;
    assign ll_ready  = Reset_L && !full;
    assign issue_ok  = Reset_L && !full && !busy[ll_issue_rw];
    assign raw_stall = Reset_L && (busy[rs_q] || busy[rt_q]);
    assign push      = ll_valid && ll_ready;

    always_comb begin
        regWrite5 = 1'b0;
        rw5       = 5'd0;
        Busw      = 32'd0;
        if (head_commit) begin
            // A result destined for r0 drains through the port without writing.
            regWrite5 = (head_rw != 5'd0);
            rw5       = head_rw;
            Busw      = head_data;
        end else if (wb_win) begin
            regWrite5 = 1'b1;
            rw5       = wb_rw;
            Busw      = wb_data;
        end
    end

    always_comb begin
        set_vec = 32'd0;
        clr_vec = 32'd0;
        if (ll_issue && issue_ok && (ll_issue_rw != 5'd0)) begin
            set_vec = 32'd1 << ll_issue_rw;
        end
        if (head_commit) begin
            clr_vec = 32'd1 << head_rw;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (head_commit) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(head_commit);
            busy  <= ((busy & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rw[wr_ptr]   <= ll_rw;
            fifo_data[wr_ptr] <= ll_data;
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - self-checking bench for regfile_write_scheduler

module tb_regfile_write_scheduler;

`ifdef RFSCHED_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        CLK;
    logic        Reset_L;
    logic        wb_valid;
    logic [4:0]  wb_rw;
    logic [31:0] wb_data;
    logic        ll_issue;
    logic [4:0]  ll_issue_rw;
    logic        ll_valid;
    logic [4:0]  ll_rw;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic        raw_stall;
    logic        issue_ok;
    logic        wb_stall;
    logic [4:0]  rw5;
    logic        regWrite5;
    logic [31:0] Busw;

    int checks = 0;
    int passed = 0;

    // Expected mul/div register-file commits, {rw, data}, in order.
    logic [36:0] ll_q[$];
    logic [36:0] exp_e;

    regfile_write_scheduler #(
        .LL_DEPTH    (2),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .wb_valid   (wb_valid),
        .wb_rw      (wb_rw),
        .wb_data    (wb_data),
        .ll_issue   (ll_issue),
        .ll_issue_rw(ll_issue_rw),
        .ll_valid   (ll_valid),
        .ll_rw      (ll_rw),
        .ll_data    (ll_data),
        .ll_ready   (ll_ready),
        .rs_q       (rs_q),
        .rt_q       (rt_q),
        .raw_stall  (raw_stall),
        .issue_ok   (issue_ok),
        .wb_stall   (wb_stall),
        .rw5        (rw5),
        .regWrite5  (regWrite5),
        .Busw       (Busw)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rw = 0; wb_data = 0;
        ll_issue = 0; ll_issue_rw = 0;
        ll_valid = 0; ll_rw = 0; ll_data = 0;
        rs_q = 0; rt_q = 0;
    endtask

    task automatic test_reset();
        Reset_L = 0;
        wb_valid = 1; wb_rw = 5'd3; wb_data = 32'hDEAD_0003;
        ll_issue = 1; ll_issue_rw = 5'd4;
        ll_valid = 1; ll_rw = 5'd6; ll_data = 32'hDEAD_0006;
        rs_q = 5'd4; rt_q = 5'd6;
        for (int c = 0; c < 2; c++) begin
            tick();
            #3;
            checks++; if (regWrite5 !== 1'b0) $display("FAIL rst_regwrite: got %b want 0", regWrite5); else passed++;
            checks++; if (ll_ready !== 1'b0) $display("FAIL rst_ll_ready: got %b want 0", ll_ready); else passed++;
            checks++; if (issue_ok !== 1'b0) $display("FAIL rst_issue_ok: got %b want 0", issue_ok); else passed++;
            checks++; if (wb_stall !== 1'b0 || raw_stall !== 1'b0) $display("FAIL rst_stalls: got wb_stall=%b raw_stall=%b want 0/0", wb_stall, raw_stall); else passed++;
            checks++; if (rw5 !== 5'd0 || Busw !== 32'd0) $display("FAIL rst_port: got rw5=%0d Busw=%h want 0/0", rw5, Busw); else passed++;
        end
        tick();
        Reset_L = 1;
        idle();
        #3;
        checks++; if (ll_ready !== 1'b1) $display("FAIL post_rst_ll_ready: got %b want 1", ll_ready); else passed++;
        checks++; if (regWrite5 !== 1'b0) $display("FAIL post_rst_regwrite: got %b want 0", regWrite5); else passed++;
        for (int i = 0; i < 16; i++) begin
            rs_q = 5'(i);
            rt_q = 5'(i + 16);
            #1;
            checks++; if (raw_stall !== 1'b0) $display("FAIL post_rst_busy: rs=%0d rt=%0d got %b want 0", i, i + 16, raw_stall); else passed++;
            tick();
        end
        idle();
    endtask

    task automatic test_wb_passthrough();
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1; wb_rw = 5'(10 + k); wb_data = 32'hB000_0000 + 32'(k * 17);
            #3;
            checks++;
            if (regWrite5 !== 1'b1 || rw5 !== 5'(10 + k) || Busw !== 32'hB000_0000 + 32'(k * 17))
                $display("FAIL wb_pass_%0d: got we=%b rw=%0d data=%h want 1/%0d/%h", k, regWrite5, rw5, Busw, 10 + k, 32'hB000_0000 + 32'(k * 17));
            else passed++;
            checks++; if (wb_stall !== 1'b0) $display("FAIL wb_pass_stall_%0d: got %b want 0", k, wb_stall); else passed++;
            tick();
        end
        idle();
    endtask

    task automatic test_scoreboard_clear();
        ll_issue = 1; ll_issue_rw = 5'd5; rs_q = 5'd5;
        #3;
        checks++; if (issue_ok !== 1'b1) $display("FAIL sb_issue_ok: got %b want 1", issue_ok); else passed++;
        checks++; if (raw_stall !== 1'b0) $display("FAIL sb_pre_raw: got %b want 0", raw_stall); else passed++;
        tick();
        ll_issue = 0;
        ll_valid = 1; ll_rw = 5'd5; ll_data = 32'h1234_5678;
        ll_q.push_back({5'd5, 32'h1234_5678});
        #3;
        checks++; if (raw_stall !== 1'b1) $display("FAIL sb_raw_busy: got %b want 1", raw_stall); else passed++;
        checks++; if (regWrite5 !== 1'b0) $display("FAIL sb_no_write: got %b want 0", regWrite5); else passed++;
        tick();
        ll_valid = 0;
        #3;
        checks++; if (raw_stall !== 1'b1) $display("FAIL sb_raw_commit_cycle: got %b want 1", raw_stall); else passed++;
        checks++;
        if (regWrite5 !== 1'b1 || ll_q.size() == 0) $display("FAIL sb_commit: got we=%b want 1", regWrite5);
        else begin
            exp_e = ll_q.pop_front();
            if ({rw5, Busw} !== exp_e) $display("FAIL sb_commit_val: got rw=%0d data=%h want %0d/%h", rw5, Busw, exp_e[36:32], exp_e[31:0]);
            else passed++;
        end
        tick();
        #3;
        checks++; if (raw_stall !== 1'b0) $display("FAIL sb_raw_cleared: got %b want 0", raw_stall); else passed++;
        checks++; if (regWrite5 !== 1'b0) $display("FAIL sb_idle_after: got %b want 0", regWrite5); else passed++;
        tick();
        idle();
    endtask

    task automatic test_starvation();
        int stall_cycle;
        int head_cycle;
        logic [31:0] d;
        logic [31:0] prev_d;
        stall_cycle = GUARD ? 5 : -1;
        head_cycle  = GUARD ? 5 : 7;
        wb_valid = 1; wb_rw = 5'd20; wb_data = 32'hA000_0000;
        ll_valid = 1; ll_rw = 5'd7; ll_data = 32'h0000_7777;
        ll_q.push_back({5'd7, 32'h0000_7777});
        #3;
        checks++; if (regWrite5 !== 1'b1 || rw5 !== 5'd20 || Busw !== 32'hA000_0000) $display("FAIL starve_push_wb: got we=%b rw=%0d data=%h want 1/20/a0000000", regWrite5, rw5, Busw); else passed++;
        tick();
        ll_valid = 0;
        prev_d = 32'hA000_0000;
        for (int k = 1; k <= 7; k++) begin
            // WB holds its inputs on the cycle after a stall.
            d = (k == stall_cycle + 1) ? prev_d : 32'hA000_0000 + 32'(k);
            wb_valid = (k < 7);
            wb_data = d;
            #3;
            checks++; if (wb_stall !== (k == stall_cycle)) $display("FAIL starve_stall_c%0d: got %b want %b", k, wb_stall, k == stall_cycle); else passed++;
            checks++;
            if (k == head_cycle) begin
                if (regWrite5 !== 1'b1 || ll_q.size() == 0) $display("FAIL starve_head_c%0d: got we=%b want 1", k, regWrite5);
                else begin
                    exp_e = ll_q.pop_front();
                    if ({rw5, Busw} !== exp_e) $display("FAIL starve_head_val_c%0d: got rw=%0d data=%h want %0d/%h", k, rw5, Busw, exp_e[36:32], exp_e[31:0]);
                    else passed++;
                end
            end else if (k < 7) begin
                if (regWrite5 !== 1'b1 || rw5 !== 5'd20 || Busw !== d) $display("FAIL starve_wb_c%0d: got we=%b rw=%0d data=%h want 1/20/%h", k, regWrite5, rw5, Busw, d);
                else passed++;
            end else begin
                if (regWrite5 !== 1'b0) $display("FAIL starve_idle_c%0d: got %b want 0", k, regWrite5); else passed++;
            end
            prev_d = d;
            tick();
        end
        idle();
    endtask

    task automatic test_full_hold();
        int drop_at;
        bit committed;
        bit ready_ok;
        drop_at = GUARD ? 100 : 3;
        wb_valid = 1; wb_rw = 5'd21; wb_data = 32'hC000_0000;
        ll_valid = 1; ll_rw = 5'd1; ll_data = 32'h0000_0101;
        ll_issue_rw = 5'd12;
        ll_q.push_back({5'd1, 32'h0000_0101});
        #3;
        checks++; if (ll_ready !== 1'b1) $display("FAIL full_ready_a: got %b want 1", ll_ready); else passed++;
        tick();
        wb_data = 32'hC000_0001;
        ll_rw = 5'd2; ll_data = 32'h0000_0202;
        ll_q.push_back({5'd2, 32'h0000_0202});
        #3;
        checks++; if (ll_ready !== 1'b1) $display("FAIL full_ready_b: got %b want 1", ll_ready); else passed++;
        tick();
        wb_data = 32'hC000_0002;
        ll_rw = 5'd3; ll_data = 32'h0000_0303;
        #3;
        checks++; if (ll_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", ll_ready); else passed++;
        checks++; if (issue_ok !== 1'b0) $display("FAIL full_issue_ok: got %b want 0", issue_ok); else passed++;
        tick();
        committed = 0;
        ready_ok = 1;
        for (int it = 0; it < 20 && !committed; it++) begin
            wb_valid = (it < drop_at);
            wb_data = 32'hC000_0010 + 32'(it);
            #3;
            if (regWrite5 === 1'b1 && rw5 !== 5'd21) begin
                committed = 1;
                checks++;
                if (ll_q.size() == 0) $display("FAIL full_first_commit: got rw=%0d with nothing expected", rw5);
                else begin
                    exp_e = ll_q.pop_front();
                    if ({rw5, Busw} !== exp_e) $display("FAIL full_first_commit: got rw=%0d data=%h want %0d/%h", rw5, Busw, exp_e[36:32], exp_e[31:0]);
                    else passed++;
                end
            end
            if (ll_ready !== 1'b0) ready_ok = 0;
            tick();
        end
        checks++; if (!committed) $display("FAIL full_commit_timeout: got no head commit want one within 20 cycles"); else passed++;
        checks++; if (!ready_ok) $display("FAIL full_hold_ready: got ll_ready=1 while full want 0"); else passed++;
        wb_valid = 0;
        ll_q.push_back({5'd3, 32'h0000_0303});
        #3;
        checks++; if (ll_ready !== 1'b1) $display("FAIL full_accept_after_commit: got %b want 1", ll_ready); else passed++;
        checks++;
        if (regWrite5 !== 1'b1 || ll_q.size() == 0) $display("FAIL full_drain_r2: got we=%b want 1", regWrite5);
        else begin
            exp_e = ll_q.pop_front();
            if ({rw5, Busw} !== exp_e) $display("FAIL full_drain_r2: got rw=%0d data=%h want %0d/%h", rw5, Busw, exp_e[36:32], exp_e[31:0]);
            else passed++;
        end
        tick();
        ll_valid = 0;
        #3;
        checks++;
        if (regWrite5 !== 1'b1 || ll_q.size() == 0) $display("FAIL full_drain_r3: got we=%b want 1", regWrite5);
        else begin
            exp_e = ll_q.pop_front();
            if ({rw5, Busw} !== exp_e) $display("FAIL full_drain_r3: got rw=%0d data=%h want %0d/%h", rw5, Busw, exp_e[36:32], exp_e[31:0]);
            else passed++;
        end
        tick();
        #3;
        checks++; if (regWrite5 !== 1'b0) $display("FAIL full_empty: got %b want 0", regWrite5); else passed++;
        tick();
        idle();
    endtask

    task automatic test_reg0();
        bit any_we;
        any_we = 0;
        ll_issue = 1; ll_issue_rw = 5'd0;
        wb_valid = 1; wb_rw = 5'd0; wb_data = 32'hEEEE_0000;
        ll_valid = 1; ll_rw = 5'd0; ll_data = 32'hEEEE_0001;
        #3;
        if (regWrite5 !== 1'b0) any_we = 1;
        checks++; if (issue_ok !== 1'b1) $display("FAIL r0_issue_ok: got %b want 1", issue_ok); else passed++;
        tick();
        ll_issue = 0; ll_valid = 0;
        #3;
        if (regWrite5 !== 1'b0) any_we = 1;
        checks++; if (wb_stall !== 1'b0) $display("FAIL r0_wb_stall: got %b want 0", wb_stall); else passed++;
        tick();
        for (int i = 0; i < 16; i++) begin
            rs_q = 5'(i);
            rt_q = 5'(i + 16);
            #1;
            if (regWrite5 !== 1'b0) any_we = 1;
            checks++; if (raw_stall !== 1'b0) $display("FAIL r0_busy: rs=%0d rt=%0d got %b want 0", i, i + 16, raw_stall); else passed++;
            tick();
        end
        checks++; if (any_we) $display("FAIL r0_regwrite: got regWrite5=1 want never"); else passed++;
        idle();
        // An empty FIFO means the next result is the next commit.
        ll_valid = 1; ll_rw = 5'd13; ll_data = 32'h0000_1313;
        ll_q.push_back({5'd13, 32'h0000_1313});
        tick();
        ll_valid = 0;
        #3;
        checks++;
        if (regWrite5 !== 1'b1 || ll_q.size() == 0) $display("FAIL r0_drained: got we=%b want 1", regWrite5);
        else begin
            exp_e = ll_q.pop_front();
            if ({rw5, Busw} !== exp_e) $display("FAIL r0_drained: got rw=%0d data=%h want %0d/%h", rw5, Busw, exp_e[36:32], exp_e[31:0]);
            else passed++;
        end
        tick();
        idle();
    endtask

    task automatic test_illegal_issue();
        ll_issue = 1; ll_issue_rw = 5'd9;
        #3;
        checks++; if (issue_ok !== 1'b1) $display("FAIL ill_first: got %b want 1", issue_ok); else passed++;
        tick();
        #3;
        checks++; if (issue_ok !== 1'b0) $display("FAIL ill_second: got %b want 0", issue_ok); else passed++;
        tick();
        ll_issue = 0;
        ll_valid = 1; ll_rw = 5'd9; ll_data = 32'h0909_0909;
        ll_q.push_back({5'd9, 32'h0909_0909});
        rt_q = 5'd9;
        #3;
        checks++; if (raw_stall !== 1'b1) $display("FAIL ill_raw_rt: got %b want 1", raw_stall); else passed++;
        tick();
        ll_valid = 0;
        #3;
        checks++;
        if (regWrite5 !== 1'b1 || ll_q.size() == 0) $display("FAIL ill_commit: got we=%b want 1", regWrite5);
        else begin
            exp_e = ll_q.pop_front();
            if ({rw5, Busw} !== exp_e) $display("FAIL ill_commit: got rw=%0d data=%h want %0d/%h", rw5, Busw, exp_e[36:32], exp_e[31:0]);
            else passed++;
        end
        tick();
        #3;
        checks++; if (raw_stall !== 1'b0) $display("FAIL ill_cleared: got %b want 0", raw_stall); else passed++;
        tick();
        idle();
    endtask

    task automatic test_reset_midop();
        ll_issue = 1; ll_issue_rw = 5'd11;
        wb_valid = 1; wb_rw = 5'd22; wb_data = 32'hF000_0000;
        tick();
        ll_issue = 0;
        ll_valid = 1; ll_rw = 5'd11; ll_data = 32'h1111_1111;
        tick();
        ll_valid = 0;
        Reset_L = 0;
        rs_q = 5'd11;
        #3;
        checks++; if (regWrite5 !== 1'b0) $display("FAIL mid_rst_write: got %b want 0", regWrite5); else passed++;
        checks++; if (wb_stall !== 1'b0) $display("FAIL mid_rst_wb_stall: got %b want 0", wb_stall); else passed++;
        tick();
        Reset_L = 1;
        wb_valid = 0;
        #3;
        checks++; if (regWrite5 !== 1'b0) $display("FAIL mid_rst_discard: got %b want 0", regWrite5); else passed++;
        checks++; if (raw_stall !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", raw_stall); else passed++;
        checks++; if (ll_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", ll_ready); else passed++;
        tick();
        idle();
    endtask

    initial begin
        idle();
        Reset_L = 0;
        test_reset();
        test_wb_passthrough();
        test_scoreboard_clear();
        test_starvation();
        test_full_hold();
        test_reg0();
        test_illegal_issue();
        test_reset_midop();
        checks++; if (ll_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries want 0", ll_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
